zeroheti_irq_arbiter: RTL and testbench

Priority arbiter and claim sequencer for the zeroHETI interrupt path. It latches raw interrupt lines into per-line pending state and selects the highest-priority enabled pending line above a threshold. It presents the winner to the core as a registered valid/id/level triple and retires it on the core's ack/claim handshake. It sits between peripheral IRQ sources and the Ibex CLIC-mode irq_i/irq_id_o/irq_ack_o interface; its configuration is written by the HETIC register front-end.

---
 rtl/zeroheti_irq_arbiter.sv | 138 +++++++++++++
 tb/tb_zeroheti_irq_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroheti_irq_arbiter.sv
// zeroheti_irq_arbiter
//   Priority arbiter and claim sequencer for the zeroHETI interrupt path.
//   Raw lines are latched into per-line pending state (edge or level mode).
//   A combinational arbiter picks the highest-priority enabled pending line
//   whose priority is strictly above the threshold; lowest index wins ties.
//   The winner is presented to the core through a registered valid/id/level
//   triple. A claim (ack) retires the named id and forces a one-cycle bubble.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   irq_i                  raw interrupt lines (synchronous to clk_i)
//   cfg_we_i/idx/ie/edge/prio  per-line configuration write port
//   threshold_i            winner prio must be strictly greater than this
//   irq_valid_o/id_o/level_o  registered presentation to the core
//   irq_ack_i/irq_id_i     single-cycle claim of id irq_id_i
//   pending_o              current pending vector
//
// Handshake: irq_valid_o is a presentation, not a request that must be held.
// The core may ack in any cycle; irq_id_i names the claimed line regardless of
// what is presented. The cycle after any ack irq_valid_o is 0.
module zeroheti_irq_arbiter #(
  parameter  int NrIrqLines = 16,
  parameter  int NrIrqPrios = 8,
  localparam int IrqWidth   = $clog2(NrIrqLines),
  localparam int PrioWidth  = $clog2(NrIrqPrios)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NrIrqLines-1:0] irq_i,
  input  logic                  cfg_we_i,
  input  logic [IrqWidth-1:0]   cfg_idx_i,
  input  logic                  cfg_ie_i,
  input  logic                  cfg_edge_i,
  input  logic [PrioWidth-1:0]  cfg_prio_i,
  input  logic [PrioWidth-1:0]  threshold_i,
  output logic                  irq_valid_o,
  output logic [IrqWidth-1:0]   irq_id_o,
  output logic [PrioWidth-1:0]  irq_level_o,
  input  logic                  irq_ack_i,
  input  logic [IrqWidth-1:0]   irq_id_i,
  output logic [NrIrqLines-1:0] pending_o
);

  logic [NrIrqLines-1:0]                irq_q_q, irq_q_d;
  logic [NrIrqLines-1:0]                pending_q, pending_d;
  logic [NrIrqLines-1:0]                ie_q, ie_d;
  logic [NrIrqLines-1:0]                edge_q, edge_d;
  logic [NrIrqLines-1:0][PrioWidth-1:0] prio_q, prio_d;
  logic                                 valid_q, valid_d;
  logic [IrqWidth-1:0]                  id_q, id_d;
  logic [PrioWidth-1:0]                 level_q, level_d;

  logic                                 found;
  logic [IrqWidth-1:0]                  win_id;
  logic [PrioWidth-1:0]                 win_prio;

  // Configuration registers. Pending is intentionally untouched by writes.
  always_comb begin
    ie_d   = ie_q;
    edge_d = edge_q;
    prio_d = prio_q;
    if (cfg_we_i) begin
      ie_d[cfg_idx_i]   = cfg_ie_i;
      edge_d[cfg_idx_i] = cfg_edge_i;
      prio_d[cfg_idx_i] = cfg_prio_i;
    end
  end

  // Pending update. In edge mode a set event in the same cycle as a claim
  // of the same line dominates, so the new edge is never lost.
  always_comb begin
    irq_q_d   = irq_i;
    pending_d = pending_q;
    for (int i = 0; i < NrIrqLines; i++) begin
      if (edge_q[i]) begin
        pending_d[i] = (irq_i[i] & ~irq_q_q[i]) |
                       (pending_q[i] & ~(irq_ack_i && (irq_id_i == IrqWidth'(i))));
      end else begin
        pending_d[i] = irq_i[i];
      end
    end
  end

  // Arbiter: starting the running best at the threshold with a strict
  // compare enforces prio > threshold and keeps the lowest index on ties.
  always_comb begin
    found    = 1'b0;
    win_id   = '0;
    win_prio = threshold_i;
    for (int i = 0; i < NrIrqLines; i++) begin
      if (pending_q[i] && ie_q[i] && (prio_q[i] > win_prio)) begin
        found    = 1'b1;
        win_id   = IrqWidth'(i);
        win_prio = prio_q[i];
      end
    end
  end

  // Output stage: an ack blocks presentation for one cycle (the bubble) and
  // freezes id/level so the retiring id is not re-presented.
  always_comb begin
    valid_d = found & ~irq_ack_i;
    id_d    = id_q;
    level_d = level_q;
    if (found && !irq_ack_i) begin
      id_d    = win_id;
      level_d = win_prio;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q_q   <= '0;
      pending_q <= '0;
      ie_q      <= '0;
      edge_q    <= '0;
      prio_q    <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      level_q   <= '0;
    end else begin
      irq_q_q   <= irq_q_d;
      pending_q <= pending_d;
      ie_q      <= ie_d;
      edge_q    <= edge_d;
      prio_q    <= prio_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      level_q   <= level_d;
    end
  end

  assign irq_valid_o = valid_q;
  assign irq_id_o    = id_q;
  assign irq_level_o = level_q;
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_zeroheti_irq_arbiter.sv
module tb_zeroheti_irq_arbiter;
  localparam int NL = 16;
  localparam int NP = 8;
  localparam int IW = 4;
  localparam int PW = 3;
  localparam int W  = 1 + IW + PW + NL;

  logic          clk_i;
  logic          rst_ni;
  logic [NL-1:0] irq_i;
  logic          cfg_we_i;
  logic [IW-1:0] cfg_idx_i;
  logic          cfg_ie_i;
  logic          cfg_edge_i;
  logic [PW-1:0] cfg_prio_i;
  logic [PW-1:0] threshold_i;
  logic          irq_valid_o;
  logic [IW-1:0] irq_id_o;
  logic [PW-1:0] irq_level_o;
  logic          irq_ack_i;
  logic [IW-1:0] irq_id_i;
  logic [NL-1:0] pending_o;

  zeroheti_irq_arbiter #(.NrIrqLines(NL), .NrIrqPrios(NP)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .irq_i(irq_i),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_ie_i(cfg_ie_i),
    .cfg_edge_i(cfg_edge_i), .cfg_prio_i(cfg_prio_i), .threshold_i(threshold_i),
    .irq_valid_o(irq_valid_o), .irq_id_o(irq_id_o), .irq_level_o(irq_level_o),
    .irq_ack_i(irq_ack_i), .irq_id_i(irq_id_i), .pending_o(pending_o)
  );

  // Clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  string phase = "init";

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Push the expected post-edge state, advance one clock, pop and compare.
  task automatic tick(input logic v, input logic [IW-1:0] id, input logic [PW-1:0] lvl,
                      input logic [NL-1:0] pend);
    logic [W-1:0] e;
    exp_q.push_back({v, id, lvl, pend});
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    check_eq({phase, ".valid"},   32'(irq_valid_o), 32'(e[W-1]));
    check_eq({phase, ".id"},      32'(irq_id_o),    32'(e[W-2 -: IW]));
    check_eq({phase, ".level"},   32'(irq_level_o), 32'(e[NL+PW-1 -: PW]));
    check_eq({phase, ".pending"}, 32'(pending_o),   32'(e[NL-1:0]));
  endtask

  task automatic idle_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg(input int idx, input logic ie, input logic edg, input int prio);
    cfg_we_i   = 1'b1;
    cfg_idx_i  = IW'(idx);
    cfg_ie_i   = ie;
    cfg_edge_i = edg;
    cfg_prio_i = PW'(prio);
    idle_cycle();
    cfg_we_i   = 1'b0;
  endtask

  task automatic ack(input int id);
    irq_ack_i = 1'b1;
    irq_id_i  = IW'(id);
  endtask

  task automatic no_ack();
    irq_ack_i = 1'b0;
    irq_id_i  = '0;
  endtask

  // Reference arbiter for the random phase: walk priorities top-down, then
  // indices bottom-up, and take the first enabled pending line.
  logic [NL-1:0] m_ie;
  logic [PW-1:0] m_prio [NL];

  task automatic model_win(input logic [NL-1:0] pend, input int th,
                           output logic f, output logic [IW-1:0] id, output logic [PW-1:0] lvl);
    f = 1'b0; id = '0; lvl = '0;
    for (int p = NP - 1; p > th && !f; p--) begin
      for (int i = 0; i < NL && !f; i++) begin
        if (pend[i] && m_ie[i] && (int'(m_prio[i]) == p)) begin
          f = 1'b1; id = IW'(i); lvl = PW'(p);
        end
      end
    end
  endtask

  initial begin
    logic [NL-1:0] m_pend, r;
    logic [IW-1:0] m_id, w_id;
    logic [PW-1:0] m_lvl, w_lvl;
    logic          w_f;
    int            th;

    rst_ni = 1'b0; irq_i = '0; cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_ie_i = 1'b0;
    cfg_edge_i = 1'b0; cfg_prio_i = '0; threshold_i = '0; irq_ack_i = 1'b0; irq_id_i = '0;

    phase = "reset";
    idle_cycle();
    check_eq("reset.valid",   32'(irq_valid_o), 32'd0);
    check_eq("reset.id",      32'(irq_id_o),    32'd0);
    check_eq("reset.level",   32'(irq_level_o), 32'd0);
    check_eq("reset.pending", 32'(pending_o),   32'd0);
    rst_ni = 1'b1;
    idle_cycle();

    // Edge line 5, single pulse
    phase = "edge5";
    cfg(5, 1'b1, 1'b1, 3);
    irq_i = 16'h0020;
    tick(1'b0, 4'd0, 3'd0, 16'h0020);
    irq_i = '0;
    tick(1'b1, 4'd5, 3'd3, 16'h0020);

    // Lines 2 and 9 at prio 4 -> tie to lowest index, then raise 9 to prio 6
    phase = "tie";
    cfg(2, 1'b1, 1'b1, 4);
    cfg(9, 1'b1, 1'b1, 4);
    irq_i = 16'h0204;
    tick(1'b1, 4'd5, 3'd3, 16'h0224);
    irq_i = '0;
    tick(1'b1, 4'd2, 3'd4, 16'h0224);
    phase = "preempt";
    cfg_we_i = 1'b1; cfg_idx_i = 4'd9; cfg_ie_i = 1'b1; cfg_edge_i = 1'b1; cfg_prio_i = 3'd6;
    tick(1'b1, 4'd2, 3'd4, 16'h0224);
    cfg_we_i = 1'b0;
    tick(1'b1, 4'd9, 3'd6, 16'h0224);

    // Ack 9: single bubble then line 2
    phase = "ack9";
    ack(9);
    tick(1'b0, 4'd9, 3'd6, 16'h0024);
    no_ack();
    tick(1'b1, 4'd2, 3'd4, 16'h0024);
    phase = "ack5";
    ack(5);
    tick(1'b0, 4'd2, 3'd4, 16'h0004);
    no_ack();
    tick(1'b1, 4'd2, 3'd4, 16'h0004);

    // Threshold gating
    phase = "thresh";
    threshold_i = 3'd4;
    tick(1'b0, 4'd2, 3'd4, 16'h0004);
    tick(1'b0, 4'd2, 3'd4, 16'h0004);
    threshold_i = 3'd3;
    tick(1'b1, 4'd2, 3'd4, 16'h0004);
    threshold_i = 3'd0;

    // Claim of a non-pending, disabled id only produces the bubble
    phase = "bogus_claim";
    ack(12);
    tick(1'b0, 4'd2, 3'd4, 16'h0004);
    no_ack();
    tick(1'b1, 4'd2, 3'd4, 16'h0004);
    phase = "ack2";
    ack(2);
    tick(1'b0, 4'd2, 3'd4, 16'h0000);
    no_ack();
    tick(1'b0, 4'd2, 3'd4, 16'h0000);

    // Level line 7
    phase = "level7";
    cfg(7, 1'b1, 1'b0, 5);
    irq_i = 16'h0080;
    tick(1'b0, 4'd2, 3'd4, 16'h0080);
    tick(1'b1, 4'd7, 3'd5, 16'h0080);
    ack(7);
    tick(1'b0, 4'd7, 3'd5, 16'h0080);
    no_ack();
    tick(1'b1, 4'd7, 3'd5, 16'h0080);
    irq_i = '0;
    tick(1'b1, 4'd7, 3'd5, 16'h0000);
    tick(1'b0, 4'd7, 3'd5, 16'h0000);

    // Edge line 3: set coincident with claim -> set wins
    phase = "collide3";
    cfg(3, 1'b1, 1'b1, 2);
    irq_i = 16'h0008;
    ack(3);
    tick(1'b0, 4'd7, 3'd5, 16'h0008);
    no_ack();
    tick(1'b1, 4'd3, 3'd2, 16'h0008);
    irq_i = '0;
    ack(3);
    tick(1'b0, 4'd3, 3'd2, 16'h0000);
    no_ack();
    tick(1'b0, 4'd3, 3'd2, 16'h0000);

    // Random phase: all lines level mode, random enables/prios/threshold
    phase = "rand";
    for (int i = 0; i < NL; i++) begin
      m_ie[i]   = ($urandom_range(0, 3) != 0);
      m_prio[i] = PW'($urandom_range(0, NP - 1));
      cfg(i, m_ie[i], 1'b0, int'(m_prio[i]));
    end
    m_pend = '0; m_id = 4'd3; m_lvl = 3'd2;
    for (int c = 0; c < 150; c++) begin
      r  = NL'($urandom_range(0, 65535)) & NL'($urandom_range(0, 65535));
      th = $urandom_range(0, 4);
      irq_i = r;
      threshold_i = PW'(th);
      model_win(m_pend, th, w_f, w_id, w_lvl);
      if (w_f) begin
        m_id = w_id; m_lvl = w_lvl;
      end
      m_pend = r;
      tick(w_f, m_id, m_lvl, m_pend);
    end
    threshold_i = '0;

    // Asynchronous reset in the middle of a claim
    phase = "async_rst";
    irq_i = 16'hFFFF;
    idle_cycle();
    idle_cycle();
    ack(0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("async_rst.valid",   32'(irq_valid_o), 32'd0);
    check_eq("async_rst.id",      32'(irq_id_o),    32'd0);
    check_eq("async_rst.level",   32'(irq_level_o), 32'd0);
    check_eq("async_rst.pending", 32'(pending_o),   32'd0);
    irq_i = '0;
    no_ack();
    idle_cycle();
    rst_ni = 1'b1;
    phase = "post_rst";
    tick(1'b0, 4'd0, 3'd0, 16'h0000);
    // Config was cleared: line 4 is level mode, disabled
    irq_i = 16'h0010;
    tick(1'b0, 4'd0, 3'd0, 16'h0010);
    tick(1'b0, 4'd0, 3'd0, 16'h0010);
    irq_i = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
